// File: rtl/rv_decode_skid_stage.sv
// RV32I/M/Zicsr decode stage with a 2-entry skid buffer.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on the buffer occupancy, so execute back-pressure
// never reaches fetch combinationally. Every out_* is a register loaded from the
// entry that will be the head after the edge.
module rv_decode_skid_stage #(
  parameter int XLEN        = 32,
  parameter int PC_BITWIDTH = 32,
  parameter int ENABLE_M    = 1,
  parameter int ENABLE_CSR  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_IR,
  input  logic [PC_BITWIDTH-1:0] in_PC,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_IR,
  output logic [PC_BITWIDTH-1:0] out_PC,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_imm,
  output logic [19:0]            out_ctl,
  output logic                   out_illegal
);

  typedef struct packed {
    logic [31:0]            ir;
    logic [PC_BITWIDTH-1:0] pc;
    logic [XLEN-1:0]        imm;
    logic [19:0]            ctl;
    logic                   illegal;
  } entry_t;

  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  entry_t     buf_q [2];
  entry_t     buf_d [2];
  logic       head_q, head_d, tail;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  entry_t      dec;
  fmt_t        fmt;
  logic [31:0] imm32;
  logic [19:0] ctl;
  logic        ill, rd_nz;
  logic [2:0]  funct3;

  assign in_ready = (count_q != 2'd2);

  // Decode the incoming instruction into control vector, immediate and illegal flag.
  always_comb begin
    ctl    = '0;
    ill    = 1'b0;
    fmt    = FMT_NONE;
    rd_nz  = (in_IR[11:7] != 5'd0);
    funct3 = in_IR[14:12];
    if (in_IR[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (in_IR[6:2])
        OPC_OP: begin
          ctl[0] = 1'b1; ctl[1] = 1'b1; ctl[3] = rd_nz;
          if (in_IR[25]) begin
            ctl[5] = 1'b1;
            ill    = (ENABLE_M == 0);
          end else begin
            ctl[4] = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          ctl[0] = 1'b1; ctl[2] = 1'b1; ctl[3] = rd_nz; ctl[4] = 1'b1; fmt = FMT_I;
        end
        OPC_LUI:    begin ctl[2] = 1'b1; ctl[3] = rd_nz; ctl[6] = 1'b1; fmt = FMT_U; end
        OPC_AUIPC:  begin ctl[2] = 1'b1; ctl[3] = rd_nz; ctl[7] = 1'b1; fmt = FMT_U; end
        OPC_JAL:    begin ctl[3] = rd_nz; ctl[8] = 1'b1; fmt = FMT_J; end
        OPC_JALR: begin
          ctl[0] = 1'b1; ctl[2] = 1'b1; ctl[3] = rd_nz; ctl[9] = 1'b1; fmt = FMT_I;
        end
        OPC_BRANCH: begin ctl[0] = 1'b1; ctl[1] = 1'b1; ctl[10] = 1'b1; fmt = FMT_B; end
        OPC_LOAD: begin
          ctl[0] = 1'b1; ctl[2] = 1'b1; ctl[3] = rd_nz; ctl[11] = 1'b1; fmt = FMT_I;
        end
        OPC_STORE: begin
          ctl[0] = 1'b1; ctl[1] = 1'b1; ctl[2] = 1'b1; ctl[12] = 1'b1; fmt = FMT_S;
        end
        OPC_MISC: begin
          // Plain FENCE is a legal no-op for this in-order core.
          if (funct3 == 3'b001)      ctl[15] = 1'b1;
          else if (funct3 != 3'b000) ill = 1'b1;
        end
        OPC_SYSTEM: begin
          if (funct3 == 3'b000) begin
            case (in_IR[31:20])
              12'h000: ctl[18] = 1'b1;
              12'h001: ctl[19] = 1'b1;
              12'h302: ctl[16] = 1'b1;
              12'h105: ctl[17] = 1'b1;
              default: ill = 1'b1;
            endcase
          end else if (funct3 == 3'b100) begin
            ill = 1'b1;
          end else begin
            // Register forms read rs1; immediate forms (funct3[2]=1) use the zimm field.
            ctl[0]  = ~funct3[2];
            ctl[3]  = rd_nz;
            ctl[13] = 1'b1;
            ctl[14] = (in_IR[19:15] != 5'd0);
            fmt     = FMT_I;
            ill     = (ENABLE_CSR == 0);
          end
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) ctl = '0;
  end

  // Build the sign-extended immediate for the decoded format.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{in_IR[31]}}, in_IR[31:20]};
      FMT_S:   imm32 = {{20{in_IR[31]}}, in_IR[31:25], in_IR[11:7]};
      FMT_B:   imm32 = {{19{in_IR[31]}}, in_IR[31], in_IR[7], in_IR[30:25], in_IR[11:8], 1'b0};
      FMT_U:   imm32 = {in_IR[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_IR[31]}}, in_IR[31], in_IR[19:12], in_IR[20], in_IR[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec         = '0;
    dec.ir      = in_IR;
    dec.pc      = in_PC;
    dec.imm     = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
    dec.ctl     = ctl;
    dec.illegal = ill;
  end

  // Buffer next state: flush wins; otherwise write at tail and advance head on pop.
  always_comb begin
    push    = in_valid && in_ready && !flush;
    pop     = out_valid && out_ready && !flush;
    tail    = head_q ^ (count_q == 2'd1);
    buf_d   = buf_q;
    head_d  = head_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) buf_d[tail] = dec;
      if (pop)  head_d = ~head_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer storage, head pointer and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      buf_q   <= buf_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  // Output registers follow the next head entry; datapath holds when the buffer empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_IR      <= '0;
      out_PC      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_ctl     <= '0;
      out_illegal <= 1'b0;
    end else if (count_d != 2'd0) begin
      out_valid   <= 1'b1;
      out_IR      <= buf_d[head_d].ir;
      out_PC      <= buf_d[head_d].pc;
      out_rs1     <= buf_d[head_d].ir[19:15];
      out_rs2     <= buf_d[head_d].ir[24:20];
      out_rd      <= buf_d[head_d].ir[11:7];
      out_imm     <= buf_d[head_d].imm;
      out_ctl     <= buf_d[head_d].ctl;
      out_illegal <= buf_d[head_d].illegal;
    end else begin
      out_valid   <= 1'b0;
      out_ctl     <= '0;
      out_illegal <= 1'b0;
    end
  end

endmodule
